// File: rtl/dcache_pkg.sv
// Shared field widths, FSM encoding and address/byte helpers for the data cache.
package dcache_pkg;

   localparam int ADDR_W     = 8;
   localparam int TAG_W      = 3;
   localparam int IDX_W      = 3;
   localparam int OFF_W      = 2;
   localparam int BLOCK_W    = 32;
   localparam int NUM_SETS   = 1 << IDX_W;
   localparam int MEM_ADDR_W = TAG_W + IDX_W;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_e;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
      return a[OFF_W +: IDX_W];
   endfunction

   function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
      return a[OFF_W-1:0];
   endfunction

   function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] blk,
                                           input logic [OFF_W-1:0]   off);
      return blk[{off, 3'b000} +: 8];
   endfunction

   function automatic logic [BLOCK_W-1:0] set_byte(input logic [BLOCK_W-1:0] blk,
                                                   input logic [OFF_W-1:0]   off,
                                                   input logic [7:0]         b);
      logic [BLOCK_W-1:0] r;
      r = blk;
      r[{off, 3'b000} +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/dcache_storage.sv
// Cache arrays: valid/dirty/tag/data per set, combinational read of one set,
// synchronous byte write (marks dirty) and block fill (installs clean block).
module dcache_storage
   import dcache_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [IDX_W-1:0]   idx,
   output logic               rd_valid,
   output logic               rd_dirty,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [BLOCK_W-1:0] rd_data,
   input  logic               wr_en,
   input  logic [OFF_W-1:0]   wr_off,
   input  logic [7:0]         wr_byte,
   input  logic               fill_en,
   input  logic [TAG_W-1:0]   fill_tag,
   input  logic [BLOCK_W-1:0] fill_data
);

   logic [NUM_SETS-1:0] valid_q, valid_d;
   logic [NUM_SETS-1:0] dirty_q, dirty_d;
   logic [TAG_W-1:0]    tag_q  [NUM_SETS];
   logic [TAG_W-1:0]    tag_d  [NUM_SETS];
   logic [BLOCK_W-1:0]  data_q [NUM_SETS];
   logic [BLOCK_W-1:0]  data_d [NUM_SETS];

   assign rd_valid = valid_q[idx];
   assign rd_dirty = dirty_q[idx];
   assign rd_tag   = tag_q[idx];
   assign rd_data  = data_q[idx];

   // Next array contents: a fill replaces the whole set; otherwise a byte write merges into it.
   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (fill_en) begin
         valid_d[idx] = 1'b1;
         dirty_d[idx] = 1'b0;
         tag_d[idx]   = fill_tag;
         data_d[idx]  = fill_data;
      end else if (wr_en) begin
         dirty_d[idx] = 1'b1;
         data_d[idx]  = set_byte(data_q[idx], wr_off, wr_byte);
      end
   end

   // Array registers; reset wipes everything, so dirty lines are lost on reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
         for (int i = 0; i < NUM_SETS; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate cache controller: hits served with
// no stall, misses sequenced through optional write-back then block fetch.
module dcache_controller
   import dcache_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  READ,
   input  logic                  WRITE,
   input  logic [ADDR_W-1:0]     ADDRESS,
   input  logic [7:0]            WRITEDATA,
   output logic [7:0]            READDATA,
   output logic                  BUSYWAIT,
   output logic                  MEM_READ,
   output logic                  MEM_WRITE,
   output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
   output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
   input  logic [BLOCK_W-1:0]    MEM_READDATA,
   input  logic                  MEM_BUSYWAIT
);

   state_e state_q, state_d;

   logic [IDX_W-1:0]   idx;
   logic [TAG_W-1:0]   req_tag;
   logic [OFF_W-1:0]   off;
   logic               blk_valid;
   logic               blk_dirty;
   logic [TAG_W-1:0]   blk_tag;
   logic [BLOCK_W-1:0] blk_data;
   logic               req;
   logic               hit;
   logic               wr_en;
   logic               fill_en;

   assign idx      = addr_idx(ADDRESS);
   assign req_tag  = addr_tag(ADDRESS);
   assign off      = addr_off(ADDRESS);
   assign req      = READ | WRITE;
   assign hit      = blk_valid & (blk_tag == req_tag);
   assign READDATA = get_byte(blk_data, off);

   dcache_storage u_storage (
      .clk       (CLK),
      .rst_n     (RESET),
      .idx       (idx),
      .rd_valid  (blk_valid),
      .rd_dirty  (blk_dirty),
      .rd_tag    (blk_tag),
      .rd_data   (blk_data),
      .wr_en     (wr_en),
      .wr_off    (off),
      .wr_byte   (WRITEDATA),
      .fill_en   (fill_en),
      .fill_tag  (req_tag),
      .fill_data (MEM_READDATA)
   );

   // Next state and all outputs; memory requests are pure functions of state so they stay level.
   always_comb begin
      state_d       = state_q;
      BUSYWAIT      = 1'b0;
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = '0;
      MEM_WRITEDATA = '0;
      wr_en         = 1'b0;
      fill_en       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req && hit) begin
               // A simultaneous READ and WRITE is treated as a write.
               wr_en = WRITE;
            end else if (req) begin
               BUSYWAIT = 1'b1;
               state_d  = blk_dirty ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            BUSYWAIT      = 1'b1;
            MEM_WRITE     = 1'b1;
            MEM_ADDRESS   = {blk_tag, idx};
            MEM_WRITEDATA = blk_data;
            if (!MEM_BUSYWAIT) state_d = ALLOCATE;
         end
         ALLOCATE: begin
            BUSYWAIT    = 1'b1;
            MEM_READ    = 1'b1;
            MEM_ADDRESS = {req_tag, idx};
            if (!MEM_BUSYWAIT) begin
               fill_en = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset abandons any transfer in flight.
   always_ff @(posedge CLK) begin
      if (!RESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   a_no_read_and_write: assert property (@(posedge CLK) disable iff (!RESET) !(READ && WRITE))
      else $error("dcache_controller: READ and WRITE asserted together");

endmodule
